// File: rtl/tremolo_mod.sv
// tremolo_mod: amplitude-modulation stage driven by an external triangle LFO.
// Scales a streaming signed sample by gain = 2^N - ((depth*lfo_wav) >> N),
// through a two-stage valid/ready pipeline, and paces the LFO via lfo_nxt.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              effect enable (low = unity-gain bypass, LFO paused)
//   rate            accepted samples per LFO step (0 behaves as 1)
//   depth           modulation depth (0 = no modulation)
//   lfo_en, lfo_nxt enable / one-cycle step strobe to tri_wave_gen
//   lfo_wav         current LFO value from tri_wave_gen
//   s_valid/s_ready/s_data   input sample stream
//   m_valid/m_ready/m_data   output sample stream
module tremolo_mod #(
    parameter int unsigned DW = 24,
    parameter int unsigned N  = 8,
    parameter int unsigned RW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [RW-1:0] rate,
    input  logic [N-1:0]  depth,
    output logic          lfo_en,
    output logic          lfo_nxt,
    input  logic [N-1:0]  lfo_wav,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    localparam int unsigned PW = DW + N + 2;
    localparam logic [N:0]  UNITY = {1'b1, {N{1'b0}}};

    logic                 v1_q, v1_d;
    logic signed [DW-1:0] d1_q, d1_d;
    logic [N:0]           g1_q, g1_d;
    logic                 v2_q, v2_d;
    logic [DW-1:0]        d2_q, d2_d;
    logic [RW-1:0]        cnt_q, cnt_d;
    logic                 nxt_q, nxt_d;
    logic                 lfo_en_q, lfo_en_d;

    logic                 adv1_c, adv2_c, accept_c;
    logic [2*N-1:0]       att_prod_c;
    logic [N-1:0]         att_c;
    logic [N:0]           gain_c;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] shifted_c;
    logic [RW-1:0]        rate_m1_c;

    // Handshake: a stage may load when it is empty or its successor moves.
    always_comb begin
        adv2_c   = !v2_q || m_ready;
        adv1_c   = !v1_q || adv2_c;
        accept_c = s_valid && adv1_c;
    end

    // Gain from the LFO value and depth seen at accept time.
    always_comb begin
        att_prod_c = (2*N)'(depth) * (2*N)'(lfo_wav);
        att_c      = att_prod_c[2*N-1:N];
        gain_c     = en ? (UNITY - (N+1)'(att_c)) : UNITY;
    end

    // Signed multiply; the gain is zero-extended so it stays positive.
    always_comb begin
        prod_c    = PW'(d1_q) * PW'($signed({1'b0, g1_q}));
        shifted_c = prod_c >>> N;
    end

    // Rate of 0 is treated as 1, i.e. a terminal count of 0.
    always_comb begin
        rate_m1_c = (rate == '0) ? '0 : rate - RW'(1);
    end

    // Next-state for pipeline, rate counter and LFO controls.
    always_comb begin
        v1_d     = v1_q;
        d1_d     = d1_q;
        g1_d     = g1_q;
        v2_d     = v2_q;
        d2_d     = d2_q;
        cnt_d    = cnt_q;
        nxt_d    = 1'b0;
        lfo_en_d = en;

        if (adv2_c) begin
            v2_d = v1_q;
            if (v1_q) begin
                d2_d = shifted_c[DW-1:0];
            end
        end

        if (adv1_c) begin
            v1_d = s_valid;
            if (s_valid) begin
                d1_d = s_data;
                g1_d = gain_c;
            end
        end

        if (!en) begin
            cnt_d = '0;
        end else if (accept_c) begin
            if (cnt_q >= rate_m1_c) begin
                cnt_d = '0;
                nxt_d = 1'b1;
            end else begin
                cnt_d = cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            d1_q     <= '0;
            g1_q     <= '0;
            v2_q     <= 1'b0;
            d2_q     <= '0;
            cnt_q    <= '0;
            nxt_q    <= 1'b0;
            lfo_en_q <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            d1_q     <= d1_d;
            g1_q     <= g1_d;
            v2_q     <= v2_d;
            d2_q     <= d2_d;
            cnt_q    <= cnt_d;
            nxt_q    <= nxt_d;
            lfo_en_q <= lfo_en_d;
        end
    end

    assign s_ready = adv1_c;
    assign m_valid = v2_q;
    assign m_data  = d2_q;
    assign lfo_nxt = nxt_q;
    assign lfo_en  = lfo_en_q;

endmodule

// File: tb/tb_tremolo_mod.sv
// Scoreboard bench for tremolo_mod: the driver pushes hand-computed expected
// samples on accept, the monitor pops and compares on each output handshake.
module tb_tremolo_mod;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] rate = 16'd1;
    logic [7:0]  depth = 8'd0;
    logic        lfo_en;
    logic        lfo_nxt;
    logic [7:0]  lfo_wav = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = 24'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [23:0] m_data;

    int tests_run = 0;
    int failed = 0;
    int exp_q[$];
    int pulse_q[$];
    int acc_cnt = 0;

    tremolo_mod dut (
        .clk(clk), .rst(rst), .en(en), .rate(rate), .depth(depth),
        .lfo_en(lfo_en), .lfo_nxt(lfo_nxt), .lfo_wav(lfo_wav),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        tests_run++;
        if (got != want) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: LFO pulses tagged with the accept count, then output scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (lfo_nxt) pulse_q.push_back(acc_cnt);
            if (s_valid && s_ready) acc_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'($signed(m_data)), 0);
                    if (int'($signed(m_data)) == 0) begin
                        failed++;
                        $display("FAIL unexpected_output: got output with empty scoreboard");
                    end
                end else begin
                    check("m_data", int'($signed(m_data)), exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input int d, input int e, input bit push);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        s_valid = 1'b1;
        s_data  = 24'(d);
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                if (push) exp_q.push_back(e);
                done = 1'b1;
            end else if (++guard > 50) begin
                check("send_timeout", 0, 1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_pulses(input string name, input int base, input int first,
                                input int step, input int count);
        int got_n;
        got_n = pulse_q.size() - first;
        check({name, "_count"}, got_n, count);
        for (int i = 0; i < count && i < got_n; i++)
            check({name, "_at"}, pulse_q[first + i] - base, step * (i + 1));
    endtask

    int ramp_in[10]  = '{-5001, -4001, -3001, -2001, -1001, -1, 999, 1999, 2999, 3999};
    int ramp_exp[10] = '{-3751, -3001, -2251, -1501, -751, -1, 749, 1499, 2249, 2999};

    initial begin
        int base;
        int first;
        int held;
        int guard;

        #23;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_lfo_nxt", int'(lfo_nxt), 0);
        check("rst_lfo_en", int'(lfo_en), 0);
        check("rst_s_ready", int'(s_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Unity at zero depth, with latency check
        en = 1'b1; rate = 16'd1000; depth = 8'd0; lfo_wav = 8'd200;
        send(1048576, 1048576, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", int'(m_valid), 0);
        @(negedge clk);
        check("lat_valid", int'(m_valid), 1);
        check("lat_data", int'($signed(m_data)), 1048576);
        idle(2);
        check("lfo_en_follows", int'(lfo_en), 1);

        // Maximum attenuation, negative rounding
        depth = 8'd255; lfo_wav = 8'd255;
        send(1048576, 8192, 1'b1);
        send(-1, -1, 1'b1);
        depth = 8'd128; lfo_wav = 8'd128;
        send(-256, -192, 1'b1);
        idle(4);

        // Rate 4, continuous stream of 12
        en = 1'b0; idle(1); en = 1'b1;
        rate = 16'd4; depth = 8'd0;
        base = acc_cnt; first = pulse_q.size();
        for (int k = 0; k < 12; k++) send(100 + k, 100 + k, 1'b1);
        idle(4);
        check_pulses("rate4", base, first, 4, 3);

        // Rate 0 behaves as 1
        en = 1'b0; idle(1); en = 1'b1;
        rate = 16'd0;
        base = acc_cnt; first = pulse_q.size();
        for (int k = 0; k < 3; k++) send(-7 - k, -7 - k, 1'b1);
        idle(4);
        check_pulses("rate0", base, first, 1, 3);

        // Bypass: no pulses, unity gain despite modulation settings
        en = 1'b0; rate = 16'd1; depth = 8'd255; lfo_wav = 8'd255;
        first = pulse_q.size();
        for (int k = 0; k < 3; k++) send(-300000 + k, -300000 + k, 1'b1);
        idle(4);
        check("bypass_pulses", pulse_q.size() - first, 0);
        check("bypass_lfo_en", int'(lfo_en), 0);

        // Backpressure with 10-sample ramp
        en = 1'b1; rate = 16'd1000; depth = 8'd128; lfo_wav = 8'd128;
        fork
            begin
                for (int k = 0; k < 10; k++) send(ramp_in[k], ramp_exp[k], 1'b1);
                s_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("bp_s_ready_low", int'(s_ready), 0);
                check("bp_m_valid_held", int'(m_valid), 1);
                held = int'($signed(m_data));
                repeat (2) @(negedge clk);
                check("bp_m_data_stable", int'($signed(m_data)), held);
                check("bp_s_ready_still_low", int'(s_ready), 0);
                @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        idle(5);

        // Asynchronous reset with two samples in flight
        en = 1'b0; idle(1); en = 1'b1;
        rate = 16'd2; depth = 8'd0; m_ready = 1'b0;
        send(555, 555, 1'b0);
        send(666, 666, 1'b0);
        s_valid = 1'b0;
        check("pre_rst_m_valid", int'(m_valid), 1);
        check("pre_rst_lfo_nxt", int'(lfo_nxt), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_m_valid", int'(m_valid), 0);
        check("arst_lfo_nxt", int'(lfo_nxt), 0);
        check("arst_cnt", int'(dut.cnt_q), 0);
        check("arst_s_ready", int'(s_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        send(777, 777, 1'b1);
        s_valid = 1'b0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
